// File: rtl/poly_arith_pkg.sv
// Shared types and constants for ML-KEM polynomial arithmetic over Z_q.
package poly_arith_pkg;

  localparam int unsigned COEFF_W = 12;
  typedef logic [COEFF_W-1:0] coeff_t;
  localparam coeff_t Q = 12'd3329;

  // One extra bit holds an unreduced sum of two coefficients.
  typedef logic [COEFF_W:0] coeff_wide_t;
  localparam coeff_wide_t Q_WIDE = 13'd3329;

  localparam int unsigned MAX_MOD_LANES = 16;

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of modular add/sub: a pre half producing the raw sum and compare
// flag, and a post half applying the conditional subtract of Q.
module mod_addsub_lane
  import poly_arith_pkg::*;
(
  input  logic [COEFF_W-1:0] a,
  input  logic [COEFF_W-1:0] b,
  input  logic               sub,
  output logic [COEFF_W:0]   pre_raw,
  output logic               pre_ge,
  input  logic [COEFF_W:0]   post_raw,
  input  logic               post_ge,
  output logic [COEFF_W-1:0] post_res
);

  coeff_wide_t a_w;
  coeff_wide_t b_w;
  coeff_wide_t addend;
  coeff_wide_t reduced;

  assign a_w = {1'b0, a};
  assign b_w = {1'b0, b};

  // Subtraction becomes a + (Q - b), so both modes share one reduction step.
  assign addend  = sub ? (Q_WIDE - b_w) : b_w;
  assign pre_raw = a_w + addend;
  assign pre_ge  = (pre_raw >= Q_WIDE);

  assign reduced  = post_raw - Q_WIDE;
  assign post_res = post_ge ? reduced[COEFF_W-1:0] : post_raw[COEFF_W-1:0];

endmodule

// File: rtl/mod_addsub_pipe.sv
// Multi-lane pipelined modular add/sub over Z_q with a single global stall.
// Bubbles are kept; every stage advances together whenever the output is free.
module mod_addsub_pipe
  import poly_arith_pkg::*;
#(
  parameter int unsigned LANES       = 4,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     sub_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic [LANES*COEFF_W-1:0] op1_i,
  input  logic [LANES*COEFF_W-1:0] op2_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [TAG_W-1:0]         tag_o,
  output logic [LANES*COEFF_W-1:0] result_o
);

  localparam int unsigned DW = LANES * COEFF_W;
  localparam int unsigned WW = LANES * (COEFF_W + 1);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
    $error("mod_addsub_pipe: PIPE_STAGES must be 1..3, got %0d", PIPE_STAGES);
  end
  if (LANES < 1 || LANES > MAX_MOD_LANES) begin : g_bad_lanes
    $error("mod_addsub_pipe: LANES must be 1..%0d, got %0d", MAX_MOD_LANES, LANES);
  end

  logic adv;
  assign adv     = !valid_o || ready_i;
  assign ready_o = adv && !rst;

  // Valid and tag shift registers, one entry per pipeline stage.
  logic             vld_reg [PIPE_STAGES];
  logic [TAG_W-1:0] tag_reg [PIPE_STAGES];

  genvar gi;
  for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    logic             vld_next;
    logic [TAG_W-1:0] tag_next;
    if (gi == 0) begin : g_head
      assign vld_next = valid_i;
      assign tag_next = tag_i;
    end else begin : g_body
      assign vld_next = vld_reg[gi-1];
      assign tag_next = tag_reg[gi-1];
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_reg[gi] <= 1'b0;
        tag_reg[gi] <= '0;
      end else if (adv) begin
        vld_reg[gi] <= vld_next;
        tag_reg[gi] <= tag_next;
      end
    end
  end

  assign valid_o = vld_reg[PIPE_STAGES-1];
  assign tag_o   = tag_reg[PIPE_STAGES-1];

  logic [WW-1:0]    pre_raw;
  logic [LANES-1:0] pre_ge;
  logic [WW-1:0]    post_raw_sel;
  logic [LANES-1:0] post_ge_sel;
  logic [DW-1:0]    post_res;

  for (gi = 0; gi < LANES; gi++) begin : g_lane
    mod_addsub_lane u_lane (
      .a        (op1_i[gi*COEFF_W +: COEFF_W]),
      .b        (op2_i[gi*COEFF_W +: COEFF_W]),
      .sub      (sub_i),
      .pre_raw  (pre_raw[gi*(COEFF_W+1) +: COEFF_W+1]),
      .pre_ge   (pre_ge[gi]),
      .post_raw (post_raw_sel[gi*(COEFF_W+1) +: COEFF_W+1]),
      .post_ge  (post_ge_sel[gi]),
      .post_res (post_res[gi*COEFF_W +: COEFF_W])
    );
  end

  if (PIPE_STAGES == 1) begin : g_one
    logic [DW-1:0] res_reg;
    assign post_raw_sel = pre_raw;
    assign post_ge_sel  = pre_ge;
    always_ff @(posedge clk) begin
      if (rst) begin
        res_reg <= '0;
      end else if (adv) begin
        res_reg <= post_res;
      end
    end
    assign result_o = res_reg;
  end else begin : g_multi
    logic [WW-1:0]    raw_reg;
    logic [LANES-1:0] ge_reg;
    logic [DW-1:0]    red_reg;
    // Stage 1 holds the unreduced sum and flag; stage 2 holds the reduced value.
    assign post_raw_sel = raw_reg;
    assign post_ge_sel  = ge_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        raw_reg <= '0;
        ge_reg  <= '0;
        red_reg <= '0;
      end else if (adv) begin
        raw_reg <= pre_raw;
        ge_reg  <= pre_ge;
        red_reg <= post_res;
      end
    end
    if (PIPE_STAGES == 3) begin : g_retime
      logic [DW-1:0] out_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          out_reg <= '0;
        end else if (adv) begin
          out_reg <= red_reg;
        end
      end
      assign result_o = out_reg;
    end else begin : g_direct
      assign result_o = red_reg;
    end
  end

endmodule
